// File: rtl/uart_fifo_param_if.sv
// -----------------------------------------------------------------------------
// uart_fifo_param_if
// Bus bundle for one uart_fifo_param instance (TX or RX byte path).
//
// Handshake: a request (write / read) is a single-cycle level sampled on the
// rising clock edge; there is no ready signal. The FIFO reports acceptance
// after the fact: a refused write sets overflow, a refused read sets
// underflow, and an accepted read is followed one cycle later by rd_valid
// with the word on data_out. flush outranks both requests in its cycle.
//
// Signals (direction seen from the FIFO, i.e. the slave modport):
//   flush        in   synchronous clear of contents and pointers
//   data_in      in   write data, DATA_WIDTH bits
//   write        in   write request
//   read         in   read request
//   err_clr      in   clears the sticky overflow/underflow flags
//   data_out     out  registered read data
//   rd_valid     out  data_out holds the word read on the previous cycle
//   full/empty   out  occupancy flags
//   level        out  occupancy, $clog2(DEPTH+1) bits
//   almost_full  out  watermark flag
//   almost_empty out  watermark flag
//   overflow     out  sticky: a write was refused
//   underflow    out  sticky: a read was refused
//   error        out  overflow | underflow
// -----------------------------------------------------------------------------
interface uart_fifo_param_if #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16
);
    logic                           flush;
    logic [DATA_WIDTH-1:0]          data_in;
    logic                           write;
    logic                           read;
    logic                           err_clr;
    logic [DATA_WIDTH-1:0]          data_out;
    logic                           rd_valid;
    logic                           full;
    logic                           empty;
    logic [$clog2(DEPTH+1)-1:0]     level;
    logic                           almost_full;
    logic                           almost_empty;
    logic                           overflow;
    logic                           underflow;
    logic                           error;

    modport master (
        output flush, data_in, write, read, err_clr,
        input  data_out, rd_valid, full, empty, level,
               almost_full, almost_empty, overflow, underflow, error
    );

    modport slave (
        input  flush, data_in, write, read, err_clr,
        output data_out, rd_valid, full, empty, level,
               almost_full, almost_empty, overflow, underflow, error
    );
endinterface

// File: rtl/uart_fifo_param.sv
// -----------------------------------------------------------------------------
// uart_fifo_param
// Parametrised synchronous FIFO used as the UART TX/RX byte buffer.
// Registered read data (1-cycle latency, rd_valid strobe), occupancy count,
// sticky overflow/underflow flags with explicit clear, synchronous flush.
//
// Optional feature: define UART_FIFO_WATERMARK_EN to get registered
// almost_full (level >= AF_LEVEL) / almost_empty (level <= AE_LEVEL).
// Without it both flags are tied low; the ports are present either way.
//
// Ports:
//   clk    in  single clock, rising edge
//   reset  in  asynchronous, active-high reset
//   bus    uart_fifo_param_if.slave - requests in, data/status out
// -----------------------------------------------------------------------------
module uart_fifo_param #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AF_LEVEL   = DEPTH - 2,
    parameter int AE_LEVEL   = 2
) (
    input  logic              clk,
    input  logic              reset,
    uart_fifo_param_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH + 1);
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

    // Elaboration-time sanity check on the configuration.
    if (DATA_WIDTH < 1 || DEPTH < 2 || AF_LEVEL < 1 || AF_LEVEL > DEPTH ||
        AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_cfg
        $error("uart_fifo_param: illegal parameter combination");
    end

    logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [LVL_W-1:0]      r_level;
    logic [DATA_WIDTH-1:0] r_data_out;
    logic                  r_rd_valid;
    logic                  r_overflow;
    logic                  r_underflow;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_rd_ok;
    logic                  w_wr_ok;
    logic                  w_wr_rej;
    logic                  w_rd_rej;
    logic [LVL_W-1:0]      w_level_nxt;

    // Explicit wrap so non-power-of-2 depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_full  = (r_level == FULL_LVL);
    assign w_empty = (r_level == '0);

    // A read frees a slot in the same cycle, so a full FIFO still takes a
    // write alongside an accepted read. An empty FIFO never forwards the
    // incoming word to a same-cycle read.
    assign w_rd_ok  = bus.read & ~w_empty;
    assign w_wr_ok  = bus.write & (~w_full | w_rd_ok);
    // Requests made during a flush are dropped silently.
    assign w_wr_rej = ~bus.flush & bus.write & ~w_wr_ok;
    assign w_rd_rej = ~bus.flush & bus.read & ~w_rd_ok;

    always_comb begin
        w_level_nxt = r_level;
        if (bus.flush) begin
            w_level_nxt = '0;
        end else if (w_wr_ok && !w_rd_ok) begin
            w_level_nxt = r_level + 1'b1;
        end else if (w_rd_ok && !w_wr_ok) begin
            w_level_nxt = r_level - 1'b1;
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (w_wr_ok && !bus.flush) begin
            r_mem[r_wr_ptr] <= bus.data_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
            r_data_out  <= '0;
            r_rd_valid  <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_level    <= w_level_nxt;
            r_rd_valid <= w_rd_ok & ~bus.flush;
            if (bus.flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_wr_ok) begin
                    r_wr_ptr <= ptr_inc(r_wr_ptr);
                end
                if (w_rd_ok) begin
                    r_rd_ptr   <= ptr_inc(r_rd_ptr);
                    r_data_out <= r_mem[r_rd_ptr];
                end
            end
            // A new rejection beats a same-cycle clear.
            if (w_wr_rej) begin
                r_overflow <= 1'b1;
            end else if (bus.err_clr) begin
                r_overflow <= 1'b0;
            end
            if (w_rd_rej) begin
                r_underflow <= 1'b1;
            end else if (bus.err_clr) begin
                r_underflow <= 1'b0;
            end
        end
    end

`ifdef UART_FIFO_WATERMARK_EN
    localparam logic [LVL_W-1:0] AF_LVL = LVL_W'(AF_LEVEL);
    localparam logic [LVL_W-1:0] AE_LVL = LVL_W'(AE_LEVEL);

    logic r_almost_full;
    logic r_almost_empty;

    // Computed from the next level so the flags change on the same edge as level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_almost_full  <= 1'b0;
            r_almost_empty <= 1'b1;
        end else begin
            r_almost_full  <= (w_level_nxt >= AF_LVL);
            r_almost_empty <= (w_level_nxt <= AE_LVL);
        end
    end

    assign bus.almost_full  = r_almost_full;
    assign bus.almost_empty = r_almost_empty;
`else
    assign bus.almost_full  = 1'b0;
    assign bus.almost_empty = 1'b0;
`endif

    assign bus.data_out  = r_data_out;
    assign bus.rd_valid  = r_rd_valid;
    assign bus.full      = w_full;
    assign bus.empty     = w_empty;
    assign bus.level     = r_level;
    assign bus.overflow  = r_overflow;
    assign bus.underflow = r_underflow;
    assign bus.error     = r_overflow | r_underflow;

endmodule

// File: tb/tb_uart_fifo_param.sv
module tb_uart_fifo_param;
  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int AF    = 6;
  localparam int AE    = 2;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  uart_fifo_param_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

  uart_fifo_param #(
    .DATA_WIDTH(DW),
    .DEPTH(DEPTH),
    .AF_LEVEL(AF),
    .AE_LEVEL(AE)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave)
  );

  // ---------------- reference model / scoreboard ----------------
  logic [DW-1:0] m_q[$];    // words currently stored
  logic [DW-1:0] exp_q[$];  // words expected on data_out, in order
  logic [DW-1:0] m_dout;
  logic          m_rv;
  logic          m_ov;
  logic          m_un;

  int checks;
  int errors;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    exp_q.delete();
    m_dout = '0;
    m_rv   = 1'b0;
    m_ov   = 1'b0;
    m_un   = 1'b0;
  endtask

  task automatic check_all(input string tag);
    logic exp_af;
    logic exp_ae;
`ifdef UART_FIFO_WATERMARK_EN
    exp_af = (m_q.size() >= AF);
    exp_ae = (m_q.size() <= AE);
`else
    exp_af = 1'b0;
    exp_ae = 1'b0;
`endif
    check({tag, ".rd_valid"}, 32'(bus.rd_valid), 32'(m_rv));
    if (m_rv) begin
      if (exp_q.size() == 0) begin
        check({tag, ".sb_underrun"}, 32'd1, 32'd0);
      end else begin
        m_dout = exp_q.pop_front();
      end
    end
    check({tag, ".data_out"}, 32'(bus.data_out), 32'(m_dout));
    check({tag, ".level"}, 32'(bus.level), 32'(m_q.size()));
    check({tag, ".full"}, 32'(bus.full), 32'(m_q.size() == DEPTH));
    check({tag, ".empty"}, 32'(bus.empty), 32'(m_q.size() == 0));
    check({tag, ".overflow"}, 32'(bus.overflow), 32'(m_ov));
    check({tag, ".underflow"}, 32'(bus.underflow), 32'(m_un));
    check({tag, ".error"}, 32'(bus.error), 32'(m_ov | m_un));
    check({tag, ".almost_full"}, 32'(bus.almost_full), 32'(exp_af));
    check({tag, ".almost_empty"}, 32'(bus.almost_empty), 32'(exp_ae));
  endtask

  // ---------------- driver ----------------
  // Called just after a rising edge: drives one cycle of requests, updates
  // the model, waits for the next edge and checks every output.
  task automatic cycle(input string tag, input logic wr, input logic [DW-1:0] d,
                       input logic rd, input logic fl, input logic ec);
    logic rd_ok;
    logic wr_ok;
    bus.write   = wr;
    bus.data_in = d;
    bus.read    = rd;
    bus.flush   = fl;
    bus.err_clr = ec;
    if (fl) begin
      m_q.delete();
      m_rv = 1'b0;
      if (ec) begin
        m_ov = 1'b0;
        m_un = 1'b0;
      end
    end else begin
      rd_ok = rd && (m_q.size() > 0);
      wr_ok = wr && ((m_q.size() < DEPTH) || rd_ok);
      if (rd_ok) exp_q.push_back(m_q.pop_front());
      if (wr_ok) m_q.push_back(d);
      m_rv = rd_ok;
      if (wr && !wr_ok) m_ov = 1'b1;
      else if (ec)      m_ov = 1'b0;
      if (rd && !rd_ok) m_un = 1'b1;
      else if (ec)      m_un = 1'b0;
    end
    @(posedge clk);
    #1;
    bus.write   = 1'b0;
    bus.read    = 1'b0;
    bus.flush   = 1'b0;
    bus.err_clr = 1'b0;
    check_all(tag);
  endtask

  task automatic wr(input string tag, input logic [DW-1:0] d);
    cycle(tag, 1'b1, d, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic rd(input string tag);
    cycle(tag, 1'b0, '0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic idle(input string tag);
    cycle(tag, 1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    checks = 0;
    errors = 0;
    model_reset();
    reset       = 1'b1;
    bus.write   = 1'b0;
    bus.read    = 1'b0;
    bus.flush   = 1'b0;
    bus.err_clr = 1'b0;
    bus.data_in = '0;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    reset = 1'b0;

    // Fill 0x01..0x08, then one rejected write.
    for (int i = 1; i <= DEPTH; i++) wr("fill", DW'(i));
    check("fill.full_after_8", 32'(bus.full), 32'd1);
    wr("overflow_wr", 8'h99);
    check("overflow.level_stays", 32'(bus.level), 32'd8);

    // Drain back-to-back, then one rejected read.
    for (int i = 0; i < DEPTH; i++) rd("drain");
    idle("drain_tail");
    rd("underflow_rd");
    check("underflow.rd_valid", 32'(bus.rd_valid), 32'd0);

    // Clear flags, refill, then simultaneous write+read while full.
    cycle("err_clr", 1'b0, '0, 1'b0, 1'b0, 1'b1);
    for (int i = 1; i <= DEPTH; i++) wr("refill", DW'(i));
    cycle("full_rw", 1'b1, 8'hAA, 1'b1, 1'b0, 1'b0);
    check("full_rw.data_out", 32'(bus.data_out), 32'h01);
    for (int i = 0; i < DEPTH; i++) rd("wrap_drain");
    check("wrap.last_word", 32'(bus.data_out), 32'hAA);

    // Empty: write+read together -> read refused, no fall-through.
    cycle("empty_rw", 1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
    rd("after_empty_rw");
    check("after_empty_rw.data", 32'(bus.data_out), 32'h55);
    cycle("clr_vs_rej", 1'b0, '0, 1'b1, 1'b0, 1'b1);
    check("clr_vs_rej.underflow", 32'(bus.underflow), 32'd1);
    cycle("clr_only", 1'b0, '0, 1'b0, 1'b0, 1'b1);

    // Level 5, flush with write (and a read) in the same cycle.
    for (int i = 0; i < 5; i++) wr("pre_flush", DW'(8'h30 + i));
    cycle("flush", 1'b1, 8'hEE, 1'b1, 1'b1, 1'b0);
    wr("post_flush", 8'h61);
    rd("post_flush_rd");
    check("post_flush.data", 32'(bus.data_out), 32'h61);

    // Reset in the middle of a burst, asserted away from the clock edge.
    for (int i = 0; i < 3; i++) wr("burst", DW'(8'h70 + i));
    bus.write   = 1'b1;
    bus.data_in = 8'h7F;
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_all("mid_reset");
    bus.write = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_all("mid_reset_hold");
    for (int i = 0; i < 3; i++) wr("after_reset", DW'(8'hC0 + i));
    for (int i = 0; i < 3; i++) rd("after_reset_rd");

    // Watermark walk: one word at a time up to full, then down.
    for (int i = 0; i < DEPTH; i++) wr("wm_up", DW'(8'hD0 + i));
    for (int i = 0; i < DEPTH; i++) rd("wm_down");

    // Random mix against the model.
    for (int i = 0; i < 200; i++) begin
      cycle("rand", 1'($urandom_range(0, 1)), DW'($urandom_range(0, 255)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 19) == 0),
            1'($urandom_range(0, 7) == 0));
    end
    idle("final_idle");
    check("sb.drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_fifo_param.md
Name: uart_fifo_param

Overview:
- Parametrised synchronous FIFO, next generation of the UART byte buffer; one instance per TX and RX path between the register interface and the UART shifters.
- Adds configurable data width and depth, occupancy count, and registered read data with a valid strobe.
- Adds sticky overflow/underflow flags with explicit clear, and a synchronous flush.
- Optional almost-full/almost-empty watermarks.

Parameters:
- DATA_WIDTH, 8, width of each stored word (>=1).
- DEPTH, 16, number of entries (>=2, need not be a power of 2).
- AF_LEVEL, DEPTH-2, almost_full asserts when level >= AF_LEVEL (1..DEPTH).
- AE_LEVEL, 2, almost_empty asserts when level <= AE_LEVEL (0..DEPTH-1).

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous clear of contents and pointers.
- data_in  in  DATA_WIDTH  write data.
- write  in  1  write request.
- read  in  1  read request.
- err_clr  in  1  clears the sticky error flags.
- data_out  out  DATA_WIDTH  registered read data.
- rd_valid  out  1  data_out holds the word of the read accepted on the previous cycle.
- full  out  1  level == DEPTH.
- empty  out  1  level == 0.
- level  out  $clog2(DEPTH+1)  current occupancy.
- almost_full  out  1  watermark flag (see Optional Feature).
- almost_empty  out  1  watermark flag (see Optional Feature).
- overflow  out  1  sticky: a write was rejected.
- underflow  out  1  sticky: a read was rejected.
- error  out  1  overflow | underflow.

Behaviour:
- Reset (async, active-high): pointers = 0, level = 0, data_out = 0, rd_valid = 0, overflow = 0, underflow = 0; so empty = 1, full = 0. Storage array is not reset.
- Pointers are $clog2(DEPTH) bits. Each pointer advances by 1 and wraps from DEPTH-1 to 0 explicitly; no reliance on power-of-2 rollover.
- Acceptance, evaluated combinationally on the current-cycle state:
  - rd_ok = read & ~empty.
  - wr_ok = write & (~full | rd_ok).
- Write accepted: mem[wr_ptr] <= data_in, wr_ptr advances.
- Read accepted: data_out <= mem[rd_ptr] at the clock edge, rd_ptr advances, rd_valid = 1 on the next cycle. Read latency is 1 cycle.
- No read accepted: rd_valid = 0 and data_out holds its last value.
- level update: +1 on wr_ok only, -1 on rd_ok only, unchanged when both or neither.
- full, empty, error are combinational from registered state. full and empty are never 1 together.
- Simultaneous read+write:
  - When full: both accepted, level stays DEPTH, no overflow.
  - When empty: write accepted, read rejected, underflow set, level becomes 1. No fall-through: the written word is readable from the next cycle.
- Rejected write (write & ~wr_ok) sets overflow. Rejected read (read & ~rd_ok) sets underflow. Storage, pointers and level are unchanged.
- err_clr clears both flags next cycle. If a new rejection occurs in the same cycle as err_clr, set wins.
- flush has priority over read and write in the same cycle:
  - pointers = 0, level = 0, rd_valid = 0.
  - data_out, overflow, underflow retained.
  - No error is flagged for requests in the flush cycle.
- Reset asserted mid-operation aborts everything immediately. The first accepted write after release lands at entry 0.

Optional Feature:
- Macro UART_FIFO_WATERMARK_EN.
- Defined:
  - almost_full = (level >= AF_LEVEL), registered and updated with level.
  - almost_empty = (level <= AE_LEVEL), registered and updated with level.
  - Reset values: almost_full = 0, almost_empty = 1.
- Undefined: almost_full and almost_empty are tied to 0. Ports remain present so the interface is identical.

Test Plan:
- DEPTH=8, DATA_WIDTH=8: write 0x01..0x08 on consecutive cycles -> full=1 after 8th, level=8. One more write -> overflow=1, level stays 8, error=1.
- Full FIFO, read 8 times back-to-back -> data_out 0x01..0x08 each one cycle after its read with rd_valid=1. Then empty=1, level=0. Read again -> underflow=1, rd_valid=0.
- Full FIFO, write 0xAA + read together -> data_out=0x01, level=8, overflow=0. After 8 further reads the last word out is 0xAA (wrap-around check).
- Empty FIFO, write 0x55 + read together -> underflow=1, level=1. Next-cycle read returns 0x55. err_clr pulsed alongside a rejected read -> underflow stays 1.
- Level 5, assert flush with write -> level=0, empty=1, rd_valid=0, no overflow. Assert reset mid-burst -> all outputs at reset values; next write lands at entry 0.
- UART_FIFO_WATERMARK_EN, DEPTH=8, AF_LEVEL=6, AE_LEVEL=2: fill one word at a time -> almost_empty drops when level=3, almost_full rises when level=6. Without the macro both stay 0.
